// File: rtl/nz_pair_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : nz_pair_fetch
//  Purpose  : Walks one CSR row of interleaved (value, column) word pairs,
//             drives the even-step counter enable, and streams each pair out
//             over valid/ready. Optional macro NZ_ZERO_SKIP_EN drops pairs
//             whose value is zero.
//  Revision : 1.0 - initial release
// ============================================================================
module nz_pair_fetch #(
    parameter int COUNT_LEN = 10,
    parameter int DATA_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [COUNT_LEN:0]   row_end,
    input  logic [COUNT_LEN:0]   addr_in,
    output logic                 cnt_enable,
    output logic [COUNT_LEN:0]   mem_addr,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_val,
    output logic [DATA_W-1:0]    out_col,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CHECK  = 3'd1;
    localparam logic [2:0] c_RD_VAL = 3'd2;
    localparam logic [2:0] c_RD_COL = 3'd3;
    localparam logic [2:0] c_OUT    = 3'd4;

    localparam logic [COUNT_LEN:0]   c_ODD_BIT   = (COUNT_LEN+1)'(1);
    localparam logic [COUNT_LEN:0]   c_EVEN_MASK = ~c_ODD_BIT;
    localparam logic [COUNT_LEN+1:0] c_STEP      = (COUNT_LEN+2)'(2);

    logic [2:0]           r_state;
    logic [COUNT_LEN:0]   r_end;
    logic [COUNT_LEN:0]   r_addr_hold;
    logic [DATA_W-1:0]    r_val;
    logic [DATA_W-1:0]    r_col;
    logic                 r_last;
    logic                 r_cnt_en;
    logic                 r_valid;
    logic                 r_done;

    logic                 w_empty;
    logic                 w_last;
    logic                 w_hs;
    logic                 w_drop;
    logic [COUNT_LEN+1:0] w_next_wide;
    logic [COUNT_LEN:0]   w_addr_next;

    assign w_empty     = (addr_in >= r_end);
    // One extra bit so a row ending at the top of the address space never wraps.
    assign w_next_wide = {1'b0, addr_in} + c_STEP;
    assign w_last      = (w_next_wide >= {1'b0, r_end});
    assign w_addr_next = w_next_wide[COUNT_LEN:0];
    assign w_hs        = r_valid && out_ready;

`ifdef NZ_ZERO_SKIP_EN
    assign w_drop = (r_state == c_RD_COL) && (r_val == '0);
`else
    assign w_drop = 1'b0;
`endif

    // Read address is presented one state ahead of the capture of its data.
    always_comb begin
        mem_addr = r_addr_hold;
        case (r_state)
            c_CHECK:  if (!w_empty)          mem_addr = addr_in;
            c_RD_VAL:                        mem_addr = addr_in | c_ODD_BIT;
            c_RD_COL: if (w_drop && !w_last) mem_addr = w_addr_next;
            c_OUT:    if (w_hs && !r_last)   mem_addr = addr_in;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_hold <= '0;
        end else begin
            r_addr_hold <= mem_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_end    <= '0;
            r_val    <= '0;
            r_col    <= '0;
            r_last   <= 1'b0;
            r_cnt_en <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_cnt_en <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_end   <= row_end & c_EVEN_MASK;
                        r_state <= c_CHECK;
                    end
                end
                c_CHECK: begin
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_state <= c_RD_VAL;
                    end
                end
                c_RD_VAL: begin
                    r_val    <= mem_rdata;
                    r_cnt_en <= 1'b1;
                    r_state  <= c_RD_COL;
                end
                c_RD_COL: begin
                    r_col <= mem_rdata;
                    if (w_drop) begin
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_state <= c_RD_VAL;
                        end
                    end else begin
                        r_last  <= w_last;
                        r_valid <= 1'b1;
                        r_state <= c_OUT;
                    end
                end
                c_OUT: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= c_IDLE;
                        end else begin
                            r_state <= c_RD_VAL;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign cnt_enable = r_cnt_en;
    assign out_valid  = r_valid;
    assign out_val    = r_val;
    assign out_col    = r_col;
    assign out_last   = r_last;
    assign busy       = (r_state != c_IDLE);
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_nz_pair_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nz_pair_fetch
//  Purpose  : Directed self-checking bench for nz_pair_fetch with an even
//             counter model and a synchronous-read memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nz_pair_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] row_end;
    logic [10:0] cnt_addr;
    logic        cnt_enable;
    logic [10:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_val;
    logic [15:0] out_col;
    logic        out_last;
    logic        busy;
    logic        done;

    logic        ld;
    logic [10:0] ld_val;
    logic [15:0] mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    int          nb, ncnt, done_cyc, first_cyc, last_hs, busy_at_done;
    int          st_seen, st_cnt, st_chg;
    logic [15:0] s_val, s_col;
    logic [15:0] b_val [0:7];
    logic [15:0] b_col [0:7];
    logic        b_last[0:7];

    always #5 clk = ~clk;

    nz_pair_fetch #(.COUNT_LEN(10), .DATA_W(16)) dut (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .row_end    (row_end),
        .addr_in    (cnt_addr),
        .cnt_enable (cnt_enable),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_val    (out_val),
        .out_col    (out_col),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // Upstream even-step counter.
    always @(posedge clk) begin
        if (ld)              cnt_addr <= ld_val;
        else if (cnt_enable) cnt_addr <= cnt_addr + 11'd2;
    end

    always @(posedge clk) mem_rdata <= mem[mem_addr[5:0]];

    task automatic run_row(input int a0, input int rend, input int stall_beat, input int stall_n);
        int stall_left;
        nb = 0; ncnt = 0; done_cyc = -1; first_cyc = -1; last_hs = -1; busy_at_done = -1;
        st_seen = 0; st_cnt = 0; st_chg = 0; s_val = '0; s_col = '0;
        stall_left = stall_n;
        @(negedge clk);
        ld = 1'b1; ld_val = 11'(a0);
        @(negedge clk);
        ld = 1'b0; start = 1'b1; row_end = 11'(rend); out_ready = 1'b1;
        for (int k = 1; k <= 200 && done_cyc < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (cnt_enable) ncnt++;
            if (out_valid && first_cyc < 0) first_cyc = k;
            if (out_valid && nb == stall_beat && stall_left > 0) begin
                if (stall_left == stall_n) begin
                    s_val = out_val; s_col = out_col;
                end else if (out_val !== s_val || out_col !== s_col) begin
                    st_chg++;
                end
                if (cnt_enable) st_cnt++;
                st_seen++; stall_left--;
                out_ready = 1'b0;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    if (nb < 8) begin
                        b_val[nb] = out_val; b_col[nb] = out_col; b_last[nb] = out_last;
                    end
                    nb++; last_hs = k;
                end
            end
            if (done) begin
                done_cyc = k; busy_at_done = int'(busy);
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({out_valid, busy, done, cnt_enable, out_last} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000", {out_valid, busy, done, cnt_enable, out_last});
        end
        n_checks++;
        if (mem_addr !== 11'd0 || out_val !== 16'd0 || out_col !== 16'd0) begin
            n_fail++; $display("FAIL reset_data: addr=%0d val=%0d col=%0d want 0/0/0", mem_addr, out_val, out_col);
        end
    endtask

    task automatic test_empty_row;
        run_row(8, 8, -1, 0);
        n_checks++;
        if (done_cyc != 2) begin
            n_fail++; $display("FAIL empty_done_cycle: got %0d want 2", done_cyc);
        end
        n_checks++;
        if (first_cyc != -1 || ncnt != 0) begin
            n_fail++; $display("FAIL empty_no_activity: first_valid=%0d cnt=%0d want -1/0", first_cyc, ncnt);
        end
        n_checks++;
        if (busy_at_done != 0) begin
            n_fail++; $display("FAIL empty_busy_at_done: got %0d want 0", busy_at_done);
        end
    endtask

    task automatic test_three_pair;
        run_row(0, 6, -1, 0);
        n_checks++;
        if (nb != 3) begin
            n_fail++; $display("FAIL three_beats: got %0d want 3", nb);
        end else begin
            n_checks++;
            if (b_val[0] !== 16'd5 || b_col[0] !== 16'd2 || b_last[0] !== 1'b0 ||
                b_val[1] !== 16'd7 || b_col[1] !== 16'd0 || b_last[1] !== 1'b0 ||
                b_val[2] !== 16'd9 || b_col[2] !== 16'd4 || b_last[2] !== 1'b1) begin
                n_fail++; $display("FAIL three_data: got (%0d,%0d,%b)(%0d,%0d,%b)(%0d,%0d,%b) want (5,2,0)(7,0,0)(9,4,1)",
                    b_val[0], b_col[0], b_last[0], b_val[1], b_col[1], b_last[1], b_val[2], b_col[2], b_last[2]);
            end
        end
        n_checks++;
        if (ncnt != 3) begin
            n_fail++; $display("FAIL three_cnt_enable: got %0d want 3", ncnt);
        end
        n_checks++;
        if (first_cyc != 4) begin
            n_fail++; $display("FAIL three_first_latency: got %0d want 4", first_cyc);
        end
        n_checks++;
        if (done_cyc != 11 || last_hs != 10) begin
            n_fail++; $display("FAIL three_done_timing: done=%0d last_hs=%0d want 11/10", done_cyc, last_hs);
        end
    endtask

    task automatic test_back_pressure;
        run_row(0, 6, 1, 5);
        n_checks++;
        if (st_seen != 5 || s_val !== 16'd7 || s_col !== 16'd0 || st_chg != 0) begin
            n_fail++; $display("FAIL bp_hold: stalls=%0d val=%0d col=%0d changes=%0d want 5/7/0/0", st_seen, s_val, s_col, st_chg);
        end
        n_checks++;
        if (st_cnt != 0) begin
            n_fail++; $display("FAIL bp_cnt_during_stall: got %0d want 0", st_cnt);
        end
        n_checks++;
        if (nb != 3 || ncnt != 3 || done_cyc != 16) begin
            n_fail++; $display("FAIL bp_sequence: beats=%0d cnt=%0d done=%0d want 3/3/16", nb, ncnt, done_cyc);
        end
        n_checks++;
        if (nb == 3 && (b_val[2] !== 16'd9 || b_last[2] !== 1'b1 || b_last[1] !== 1'b0)) begin
            n_fail++; $display("FAIL bp_tail: val=%0d last2=%b last1=%b want 9/1/0", b_val[2], b_last[2], b_last[1]);
        end
    endtask

    task automatic test_odd_end;
        run_row(0, 5, -1, 0);
        n_checks++;
        if (nb != 2 || ncnt != 2) begin
            n_fail++; $display("FAIL odd_count: beats=%0d cnt=%0d want 2/2", nb, ncnt);
        end else begin
            n_checks++;
            if (b_val[1] !== 16'd7 || b_col[1] !== 16'd0 || b_last[1] !== 1'b1 || b_last[0] !== 1'b0) begin
                n_fail++; $display("FAIL odd_last: got (%0d,%0d,%b) first_last=%b want (7,0,1) 0", b_val[1], b_col[1], b_last[1], b_last[0]);
            end
        end
    endtask

    task automatic test_zero_values;
        run_row(16, 20, -1, 0);
        n_checks++;
        if (ncnt != 2 || done_cyc < 0) begin
            n_fail++; $display("FAIL zero_cnt_done: cnt=%0d done=%0d want 2/seen", ncnt, done_cyc);
        end
`ifdef NZ_ZERO_SKIP_EN
        n_checks++;
        if (nb != 1 || b_val[0] !== 16'd8 || b_col[0] !== 16'd1 || b_last[0] !== 1'b1) begin
            n_fail++; $display("FAIL zero_skip_beats: n=%0d (%0d,%0d,%b) want 1 (8,1,1)", nb, b_val[0], b_col[0], b_last[0]);
        end
`else
        n_checks++;
        if (nb != 2 || b_val[0] !== 16'd0 || b_col[0] !== 16'd3 || b_last[0] !== 1'b0 ||
            b_val[1] !== 16'd8 || b_col[1] !== 16'd1 || b_last[1] !== 1'b1) begin
            n_fail++; $display("FAIL zero_keep_beats: n=%0d (%0d,%0d,%b)(%0d,%0d,%b) want 2 (0,3,0)(8,1,1)",
                nb, b_val[0], b_col[0], b_last[0], b_val[1], b_col[1], b_last[1]);
        end
`endif
    endtask

    task automatic test_reset_mid_walk;
        int k;
        @(negedge clk);
        ld = 1'b1; ld_val = 11'd0;
        @(negedge clk);
        ld = 1'b0; start = 1'b1; row_end = 11'd6; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk); k++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL midwalk_reach_out: out_valid=%b want 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, busy, cnt_enable, out_last} !== 4'b0 || mem_addr !== 11'd0) begin
            n_fail++; $display("FAIL midwalk_async_reset: flags=%b addr=%0d want 0000/0", {out_valid, busy, cnt_enable, out_last}, mem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        run_row(8, 8, -1, 0);
        n_checks++;
        if (done_cyc != 2) begin
            n_fail++; $display("FAIL midwalk_restart: done=%0d want 2", done_cyc);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; row_end = '0; out_ready = 1'b1;
        ld = 1'b0; ld_val = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 16'd5; mem[1] = 16'd2; mem[2] = 16'd7;
        mem[3] = 16'd0; mem[4] = 16'd9; mem[5] = 16'd4;
        mem[16] = 16'd0; mem[17] = 16'd3; mem[18] = 16'd8; mem[19] = 16'd1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_empty_row();
        test_three_pair();
        test_back_pressure();
        test_odd_end();
        test_zero_values();
        test_reset_mid_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nz_pair_fetch.md
# nz_pair_fetch

- Walks one CSR row of the sparse operand stored as interleaved (value, column) word pairs.
- Consumes the even address produced by the upstream even-step counter and drives that counter's enable.
- Reads each pair from a synchronous-read memory and presents it as a valid/ready stream to the multiply-accumulate stage.

## Interface

**Parameters**

- COUNT_LEN, 10: address MSB index; addresses are COUNT_LEN+1 bits, matching the even counter.
- DATA_W, 16: width of memory words, values and column indices.

**Ports**

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- start  input  1  one-cycle pulse; begins a row walk when idle.
- row_end  input  COUNT_LEN+1  exclusive end address of the row; sampled on accepted start; bit 0 is ignored (forced to 0).
- addr_in  input  COUNT_LEN+1  current even address from the even counter; must equal row start when start is pulsed.
- cnt_enable  output  1  one-cycle pulse; advances the even counter by 2.
- mem_addr  output  COUNT_LEN+1  memory read address; read data is valid one cycle later.
- mem_rdata  input  DATA_W  memory read data.
- out_valid  output  1  pair available.
- out_ready  input  1  consumer accepts the pair.
- out_val  output  DATA_W  nonzero value.
- out_col  output  DATA_W  column index.
- out_last  output  1  qualifies out_valid; marks the final pair of the row.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the row is complete.

## Operation

**States:** IDLE, CHECK, RD_VAL, RD_COL, OUT.

- **IDLE**
  - start=1: latch row_end (bit 0 cleared) into end_q; go to CHECK.
  - start while busy is ignored.
- **CHECK**
  - addr_in >= end_q: pulse done and return to IDLE. This is an empty row; no beat is emitted.
  - Otherwise: mem_addr=addr_in; go to RD_VAL.
- **RD_VAL**
  - Capture val_q <= mem_rdata.
  - mem_addr = addr_in | 1.
  - Go to RD_COL.
- **RD_COL**
  - Capture col_q <= mem_rdata.
  - cnt_enable=1 for this cycle.
  - Compute last_q = (addr_in + 2 >= end_q) using COUNT_LEN+2-bit arithmetic, so there is no wrap at the top of the address space.
  - Go to OUT.
- **OUT**
  - out_valid=1; out_val, out_col and out_last are held stable until the handshake.
  - out_valid && out_ready with last_q=1: pulse done next cycle and return to IDLE.
  - out_valid && out_ready with last_q=0: go to RD_VAL with mem_addr=addr_in. addr_in is already advanced, so CHECK is skipped.
- **Outside read states:** mem_addr holds its last value. It is 0 after reset.
- **Reset mid-walk:** all state is abandoned and outputs return to their reset values immediately. Resetting the even counter is the parent's responsibility.

**Reset values:** state=IDLE; cnt_enable, out_valid, out_last, busy and done are all 0; mem_addr, out_val and out_col are 0.

## Timing

- **start to first out_valid:** 4 cycles (CHECK, RD_VAL, RD_COL, then OUT).
- **Steady state:** 3 cycles per pair (RD_VAL, RD_COL, OUT) when out_ready is held high.
- **Throughput bound:** 1 pair per 3 cycles.
- **cnt_enable:** exactly one pulse per pair, always issued in RD_COL. The counter has therefore advanced before the OUT cycle.
- **done timing:**
  - Registered; asserted the cycle after the last handshake.
  - For an empty row, asserted the cycle after CHECK.
  - busy deasserts in the same cycle that done asserts.
- **Back-pressure:** out_ready low stalls in OUT indefinitely. No reads or counter pulses occur while stalled.

## Configuration

**NZ_ZERO_SKIP_EN**

- **Defined:**
  - In RD_COL, a pair with val_q==0 is dropped: no OUT state, but cnt_enable still pulses.
  - After a drop, go to RD_VAL if last_q=0; otherwise pulse done and go to IDLE.
  - A row may therefore complete with no out_last beat. done is the sole end-of-row indicator.
- **Undefined:** every stored pair is emitted, including zero values.

## Test plan

- **Empty row:** addr_in=8, row_end=8, start.
  - Required: done pulses 2 cycles after start.
  - No out_valid and no cnt_enable occur.
- **Three-pair row:** addr_in=0, row_end=6, memory words {5,2,7,0,9,4}, out_ready=1.
  - Required beats, with out_last on the third only: (5,2), (7,0), (9,4).
  - Exactly 3 cnt_enable pulses.
  - done pulses 1 cycle after the third handshake.
- **Back-pressure:** same row, out_ready=0 for 5 cycles on the second beat.
  - Required: out_val=7 and out_col=0 held stable.
  - No cnt_enable during the stall; sequence otherwise unchanged.
- **Odd row_end:** row_end=5 from addr_in=0.
  - Required: treated as 4; exactly 2 pairs emitted.
- **Reset mid-walk:** assert reset while in OUT.
  - Required: out_valid, busy and cnt_enable are 0 immediately (asynchronous).
  - After release: state is IDLE and start is accepted again.
- **NZ_ZERO_SKIP_EN defined:** memory words {0,3,8,1}, row_end=4.
  - Required: single beat (8,1) with out_last; 2 cnt_enable pulses; done pulses.
